sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder_if.sv | 28 ++
 rtl/sram_responder.sv | 150 +++++++++++++++
 tb/tb_sram_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// CPU-side handshake and SRAM control pins for sram_responder.
// The bidirectional SRAM data bus stays a plain inout port on the module.
interface sram_responder_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR,
        input  Data_to_CPU, Mem_Ready, SRAM_ADDR,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR,
        output Data_to_CPU, Mem_Ready, SRAM_ADDR,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );
endinterface

// File: rtl/sram_responder.sv
// Async SRAM access sequencer: one read or write per request, with fixed
// OE/WE wait counts and registered strobes, address and read data.
module sram_responder #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    sram_responder_if.slave bus,
    inout  wire  [15:0]     SRAM_DQ
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_DONE  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] RD_LAST = 3'(RD_WAIT - 1);
    localparam logic [2:0] WR_LAST = 3'(WR_WAIT - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        ce_d, oe_d, we_d, be_d, dq_en_d, ready_d;
    logic        ce_n, oe_n, we_n, be_n, dq_en, ready;
    logic [15:0] addr, wdata, rdata;
    logic        start, rd_last;

    assign start   = (state == IDLE) && (bus.Mem_WE || bus.Mem_OE);
    assign rd_last = (state == RD) && (cnt == RD_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Done states hold until the request drops, so a held request is one access.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 3'd0;
                if (bus.Mem_WE)      state_nxt = WR_SETUP;
                else if (bus.Mem_OE) state_nxt = RD;
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    state_nxt = RD_DONE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            RD_DONE:  if (!bus.Mem_OE) state_nxt = IDLE;
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = 3'd0;
            end
            WR_PULSE: begin
                if (cnt == WR_LAST) begin
                    state_nxt = WR_DONE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            WR_DONE:  if (!bus.Mem_WE) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered and then registered,
    // so pins change cleanly on the same edge as the state.
    always_comb begin
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        be_d    = 1'b1;
        dq_en_d = 1'b0;
        ready_d = 1'b0;
        case (state_nxt)
            RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                be_d = 1'b0;
            end
            RD_DONE:  ready_d = 1'b1;
            WR_SETUP: begin
                ce_d    = 1'b0;
                be_d    = 1'b0;
                dq_en_d = 1'b1;
            end
            WR_PULSE: begin
                ce_d    = 1'b0;
                be_d    = 1'b0;
                we_d    = 1'b0;
                dq_en_d = 1'b1;
            end
            WR_DONE: begin
                ce_d    = 1'b0;
                be_d    = 1'b0;
                dq_en_d = 1'b1;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ce_n  <= 1'b1;
            oe_n  <= 1'b1;
            we_n  <= 1'b1;
            be_n  <= 1'b1;
            dq_en <= 1'b0;
            ready <= 1'b0;
            addr  <= 16'h0000;
            wdata <= 16'h0000;
            rdata <= 16'h0000;
        end else begin
            ce_n  <= ce_d;
            oe_n  <= oe_d;
            we_n  <= we_d;
            be_n  <= be_d;
            dq_en <= dq_en_d;
            ready <= ready_d;
            if (start)                addr  <= bus.MAR;
            if (start && bus.Mem_WE)  wdata <= bus.MDR;
            if (rd_last)              rdata <= SRAM_DQ;
        end
    end

    assign bus.Data_to_CPU = rdata;
    assign bus.Mem_Ready   = ready;
    assign bus.SRAM_ADDR   = {4'b0000, addr};
    assign bus.SRAM_CE_N   = ce_n;
    assign bus.SRAM_OE_N   = oe_n;
    assign bus.SRAM_WE_N   = we_n;
    assign bus.SRAM_UB_N   = be_n;
    assign bus.SRAM_LB_N   = be_n;
    assign SRAM_DQ         = dq_en ? wdata : 16'hzzzz;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table, randomized transactions
// against a cycle-count model of the access timing, and reset corner cases.
module tb_sram_responder;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 2;

    typedef enum int {P_IDLE, P_RD, P_RDONE, P_WSET, P_WPUL, P_WDONE} phase_t;

    typedef struct packed {
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
        logic        ready;
        logic [19:0] addr;
        logic [15:0] dcpu;
        logic [15:0] dq;
    } obs_t;

    typedef struct {
        int          op;       // 0 read, 1 write, 2 both requests
        logic [15:0] mar;
        logic [15:0] mdr;
        int          hold;
        int          exp_we_low;
        int          exp_oe_low;
        int          exp_ready;
        int          exp_idle;
        logic [15:0] exp_rdata;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    wire [15:0] dq;

    sram_responder_if bus ();

    sram_responder #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .bus     (bus),
        .SRAM_DQ (dq)
    );

    always #5 Clk = ~Clk;

    // SRAM device model; the pull-up makes an undriven bus read as FFFF.
    logic [15:0] sram_mem [0:65535];
    pullup (dq);
    assign dq = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? sram_mem[bus.SRAM_ADDR[15:0]] : 16'hzzzz;
    always @(negedge Clk)
        if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) sram_mem[bus.SRAM_ADDR[15:0]] <= dq;

    int checks = 0;
    int failures = 0;

    int   rdy_rise = 0, oe_fall = 0, we_fall = 0;
    logic p_rdy = 1'b0, p_oe = 1'b1, p_we = 1'b1;
    always @(negedge Clk) begin
        if (bus.Mem_Ready && !p_rdy)   rdy_rise <= rdy_rise + 1;
        if (!bus.SRAM_OE_N && p_oe)    oe_fall  <= oe_fall + 1;
        if (!bus.SRAM_WE_N && p_we)    we_fall  <= we_fall + 1;
        p_rdy <= bus.Mem_Ready;
        p_oe  <= bus.SRAM_OE_N;
        p_we  <= bus.SRAM_WE_N;
    end

    logic [15:0] ref_mem [logic [15:0]];
    logic [19:0] exp_addr = 20'h00000;
    logic [15:0] exp_dcpu = 16'h0000;

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ce_n  = bus.SRAM_CE_N;
        o.oe_n  = bus.SRAM_OE_N;
        o.we_n  = bus.SRAM_WE_N;
        o.ub_n  = bus.SRAM_UB_N;
        o.lb_n  = bus.SRAM_LB_N;
        o.ready = bus.Mem_Ready;
        o.addr  = bus.SRAM_ADDR;
        o.dcpu  = bus.Data_to_CPU;
        o.dq    = dq;
        return o;
    endfunction

    // Cycle k counts from the cycle the request is first presented (k=0).
    // The done phase starts at dn and lasts until the request has dropped.
    function automatic phase_t phase_of(input bit wr, input int k, input int h, input int dn);
        int e;
        e = (h > dn) ? h : dn;
        if (k == 0 || k > e) return P_IDLE;
        if (k >= dn) return wr ? P_WDONE : P_RDONE;
        if (!wr) return P_RD;
        return (k == 1) ? P_WSET : P_WPUL;
    endfunction

    task automatic run_txn(input int op, input logic [15:0] a, input logic [15:0] d,
                           input int h, input int g, input bit noise,
                           output int we_low, output int oe_low, output int rdy, output int idle_at);
        bit          wr, nz;
        int          dn, e;
        logic [15:0] rdval;
        phase_t      ph;
        obs_t        o, x;
        wr    = (op != 0);
        dn    = wr ? 2 + WR_WAIT : 1 + RD_WAIT;
        e     = (h > dn) ? h : dn;
        rdval = ref_get(a);
        we_low = 0; oe_low = 0; rdy = 0; idle_at = 0;
        for (int k = 0; k <= e + g; k++) begin
            nz = noise && (k >= 1) && (k < h) && ($urandom_range(0, 1) == 1);
            bus.Mem_WE = (op == 0) ? nz : (k < h);
            bus.Mem_OE = (op == 1) ? nz : (k < h);
            bus.MAR    = (k == 0) ? a : 16'($urandom);
            bus.MDR    = (k == 0) ? d : 16'($urandom);
            ph = phase_of(wr, k, h, dn);
            if (k == 1) exp_addr = {4'h0, a};
            if (!wr && k == dn) exp_dcpu = rdval;
            x.ce_n  = (ph == P_IDLE || ph == P_RDONE);
            x.ub_n  = x.ce_n;
            x.lb_n  = x.ce_n;
            x.oe_n  = (ph != P_RD);
            x.we_n  = (ph != P_WPUL);
            x.ready = (ph == P_RDONE || ph == P_WDONE);
            x.addr  = exp_addr;
            x.dcpu  = exp_dcpu;
            x.dq    = (ph == P_WSET || ph == P_WPUL || ph == P_WDONE) ? d :
                      (ph == P_RD) ? rdval : 16'hFFFF;
            @(negedge Clk);
            o = sample();
            chk($sformatf("cycle k=%0d %s", k, ph.name()), {6'b0, o}, {6'b0, x});
            if (!o.we_n) we_low++;
            if (!o.oe_n) oe_low++;
            if (o.ready) begin
                rdy++;
                idle_at = k + 1;
            end
            @(posedge Clk);
            #1;
        end
        bus.Mem_WE = 1'b0;
        bus.Mem_OE = 1'b0;
        if (wr) ref_mem[a] = d;
    endtask

    initial begin
        vec_t        tbl [7];
        obs_t        rst_x;
        int          wl, ol, rc, ia, op, r0, o0, w0, got;
        logic [15:0] a, d, old;

        for (int i = 0; i < 65536; i++) sram_mem[i] = 16'(i) ^ 16'hA5A5;

        tbl[0] = '{1, 16'h1234, 16'hBEEF, 3, 2, 0, 1, 5, 16'h0000};
        tbl[1] = '{0, 16'h1234, 16'h0000, 3, 0, 1, 2, 4, 16'hBEEF};
        tbl[2] = '{0, 16'h0005, 16'h0000, 6, 0, 1, 5, 7, 16'hA5A0};
        tbl[3] = '{2, 16'h0040, 16'h00FF, 2, 2, 0, 1, 5, 16'h0000};
        tbl[4] = '{0, 16'h0040, 16'h0000, 1, 0, 1, 1, 3, 16'h00FF};
        tbl[5] = '{1, 16'h0077, 16'h1357, 1, 2, 0, 1, 5, 16'h0000};
        tbl[6] = '{0, 16'h0077, 16'h0000, 2, 0, 1, 1, 3, 16'h1357};

        rst_x = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, ready: 1'b0,
                  addr: 20'h00000, dcpu: 16'h0000, dq: 16'hFFFF};

        Reset = 1'b1;
        bus.Mem_OE = 1'b0;
        bus.Mem_WE = 1'b0;
        bus.MAR = 16'h0000;
        bus.MDR = 16'h0000;
        #2 Reset = 1'b0;
        #1 chk("reset_state_async", {6'b0, sample()}, {6'b0, rst_x});
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].op, tbl[i].mar, tbl[i].mdr, tbl[i].hold, 1, 1'b0, wl, ol, rc, ia);
            chk($sformatf("vec%0d we_low_cycles", i), 64'(wl), 64'(tbl[i].exp_we_low));
            chk($sformatf("vec%0d oe_low_cycles", i), 64'(ol), 64'(tbl[i].exp_oe_low));
            chk($sformatf("vec%0d ready_cycles", i),  64'(rc), 64'(tbl[i].exp_ready));
            chk($sformatf("vec%0d idle_cycle", i),    64'(ia), 64'(tbl[i].exp_idle));
            if (tbl[i].op == 0)
                chk($sformatf("vec%0d read_data", i), 64'(bus.Data_to_CPU), 64'(tbl[i].exp_rdata));
        end

        r0 = rdy_rise; o0 = oe_fall; w0 = we_fall;
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 2);
            a  = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 5'b00000, 3'($urandom_range(0, 7))};
            d  = 16'($urandom);
            if (d == 16'hFFFF) d = 16'hFFFE;
            run_txn(op, a, d, $urandom_range(1, 7), $urandom_range(1, 3), 1'b1, wl, ol, rc, ia);
        end
        chk("ready_pulses_vs_accesses", 64'(rdy_rise - r0), 64'((oe_fall - o0) + (we_fall - w0)));

        // Reset in the middle of the WE pulse, then read the same address back.
        old = ref_get(16'h0099);
        bus.MAR = 16'h0099;
        bus.MDR = 16'hCAFE;
        bus.Mem_WE = 1'b1;
        @(posedge Clk);
        #1 bus.Mem_WE = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("mid_write_we_active", 64'(bus.SRAM_WE_N), 64'(0));
        #2 Reset = 1'b0;
        #1 chk("mid_write_reset_async", {6'b0, sample()}, {6'b0, rst_x});
        @(posedge Clk);
        #1 Reset = 1'b1;
        bus.MAR = 16'h0099;
        bus.Mem_OE = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("post_reset_first_edge_read", 64'(bus.SRAM_OE_N), 64'(0));
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge Clk);
            if (bus.Mem_Ready) got = 1;
        end
        chk("post_reset_ready_seen", 64'(got), 64'(1));
        chk("post_reset_old_or_new", 64'(bus.Data_to_CPU == old || bus.Data_to_CPU == 16'hCAFE), 64'(1));
        bus.Mem_OE = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk("post_reset_back_idle", 64'({bus.SRAM_CE_N, bus.Mem_Ready}), 64'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
